beep_scheduler: RTL and testbench

Sequences the clock's beeper between two requesters: the hourly chime and the alarm.
- Chime pattern: 512 Hz pips at xx:59:50/52/54/58, then a 1 kHz pip at xx:00:00.
- Alarm: rings for a bounded time, with snooze and stop support.
- Sits between the BCD timekeeping counters and the tone generators; outputs are tone-enable levels, updated once per second.

---
 rtl/beep_pkg.sv | 47 ++++
 rtl/sec_countdown.sv | 29 ++
 rtl/beep_scheduler.sv | 140 ++++++++++++++
 tb/tb_beep_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared types and chime timing constants for the beeper scheduler.
// Chime decode works directly on packed BCD {tens, units} bytes.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RING,
        SNOOZE
    } state_t;

    // One decision per cycle; the FSM and the countdown both act on it.
    typedef enum logic [3:0] {
        ACT_HOLD,
        ACT_CHIME,
        ACT_START,
        ACT_ABORT,
        ACT_SNOOZE,
        ACT_RING_TICK,
        ACT_RING_END,
        ACT_SNOOZE_TICK,
        ACT_RERING
    } action_t;

    typedef struct packed {
        logic b512;
        logic b1k;
    } tones_t;

    localparam logic [7:0] CHIME_MIN = 8'h59;
    localparam logic [7:0] TOP_MIN   = 8'h00;
    localparam logic [7:0] TOP_SEC   = 8'h00;
    localparam int         NUM_PIPS  = 4;
    localparam logic [7:0] PIP_SEC [NUM_PIPS] = '{8'h50, 8'h52, 8'h54, 8'h58};

    function automatic tones_t chime_tones(input logic [7:0] mm, input logic [7:0] ss);
        tones_t t;
        t.b512 = 1'b0;
        if (mm == CHIME_MIN) begin
            for (int i = 0; i < NUM_PIPS; i++) begin
                if (ss == PIP_SEC[i]) t.b512 = 1'b1;
            end
        end
        t.b1k = (mm == TOP_MIN) && (ss == TOP_SEC);
        return t;
    endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter shared by the RING and SNOOZE episodes.
// expire flags the tick that consumes the last remaining second.
module sec_countdown #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = tick && (count == WIDTH'(1));

endmodule

// File: rtl/beep_scheduler.sv
// Arbitrates the beeper between the hourly chime and the alarm ring/snooze cycle.
// Tone enables, alarm_active and snooze_used are all registered.
module beep_scheduler
    import beep_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [3:0] sec1,
    input  logic [3:0] sec2,
    input  logic [3:0] min1,
    input  logic [3:0] min2,
    input  logic [3:0] hour1,
    input  logic [3:0] hour2,
    input  logic [3:0] asec1,
    input  logic [3:0] asec2,
    input  logic [3:0] amin1,
    input  logic [3:0] amin2,
    input  logic [3:0] ahour1,
    input  logic [3:0] ahour2,
    input  logic       alarm_on,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       beep512Hz,
    output logic       beep1kHz,
    output logic       alarm_active,
    output logic [1:0] snooze_used
);

    localparam int             CW          = $clog2(((RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC) + 1);
    localparam logic [CW-1:0]  RING_LOAD   = CW'(RING_SEC);
    localparam logic [CW-1:0]  SNOOZE_LOAD = CW'(SNOOZE_SEC);
    localparam logic [1:0]     SNOOZE_CAP  = 2'(MAX_SNOOZE);

    state_t        state;
    action_t       act;
    tones_t        chime;
    logic          expire;
    logic          alarm_match;
    logic          snooze_ok;
    logic          cd_load;
    logic [CW-1:0] cd_load_val;

    assign alarm_match = alarm_on &&
        ({hour1, hour2, min1, min2, sec1, sec2} == {ahour1, ahour2, amin1, amin2, asec1, asec2});
    assign chime     = chime_tones({min1, min2}, {sec1, sec2});
    assign snooze_ok = (snooze_used < SNOOZE_CAP);

    // Priority: disarm/stop > snooze > tick; a button that acts swallows the tick.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        act = ACT_HOLD;
        case (state)
            IDLE: begin
                if (tick_1hz) act = alarm_match ? ACT_START : ACT_CHIME;
            end
            RING: begin
                if (!alarm_on || stop_btn)       act = ACT_ABORT;
                else if (snooze_btn && snooze_ok) act = ACT_SNOOZE;
                else if (tick_1hz)               act = expire ? ACT_RING_END : ACT_RING_TICK;
            end
            SNOOZE: begin
                if (!alarm_on || stop_btn) act = ACT_ABORT;
                else if (tick_1hz)         act = expire ? ACT_RERING : ACT_SNOOZE_TICK;
            end
            default: act = ACT_ABORT;
        endcase
    end

    always_comb begin
        cd_load     = 1'b1;
        cd_load_val = '0;
        case (act)
            ACT_START, ACT_RERING: cd_load_val = RING_LOAD;
            ACT_SNOOZE:            cd_load_val = SNOOZE_LOAD;
            ACT_ABORT:             cd_load_val = '0;
            default:               cd_load     = 1'b0;
        endcase
    end

    sec_countdown #(.WIDTH(CW)) u_countdown (
        .clk      (clk),
        .rst      (rst),
        .load     (cd_load),
        .load_val (cd_load_val),
        .tick     (tick_1hz),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beep512Hz    <= 1'b0;
            beep1kHz     <= 1'b0;
            alarm_active <= 1'b0;
            snooze_used  <= 2'd0;
        end else begin
            case (act)
                ACT_CHIME, ACT_SNOOZE_TICK: begin
                    beep512Hz <= chime.b512;
                    beep1kHz  <= chime.b1k;
                end
                ACT_START, ACT_RERING: begin
                    state        <= RING;
                    beep512Hz    <= 1'b0;
                    beep1kHz     <= 1'b1;
                    alarm_active <= 1'b1;
                    if (act == ACT_START) snooze_used <= 2'd0;
                end
                ACT_SNOOZE: begin
                    state       <= SNOOZE;
                    beep512Hz   <= 1'b0;
                    beep1kHz    <= 1'b0;
                    snooze_used <= snooze_used + 2'd1;
                end
                ACT_ABORT: begin
                    state        <= IDLE;
                    beep512Hz    <= 1'b0;
                    beep1kHz     <= 1'b0;
                    alarm_active <= 1'b0;
                    snooze_used  <= 2'd0;
                end
                ACT_RING_END: begin
                    // The timeout tick is a normal tick, so the chime for that second applies.
                    state        <= IDLE;
                    beep512Hz    <= chime.b512;
                    beep1kHz     <= chime.b1k;
                    alarm_active <= 1'b0;
                    snooze_used  <= 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_beep_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, compared each cycle
// against a seconds-of-day reference model of the alarm and chime rules.
module tb_beep_scheduler;

    localparam int RING_SEC   = 5;
    localparam int SNOOZE_SEC = 3;
    localparam int MAX_SNOOZE = 2;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, alarm_on, snooze_btn, stop_btn;
    logic [3:0] sec1, sec2, min1, min2, hour1, hour2;
    logic [3:0] asec1, asec2, amin1, amin2, ahour1, ahour2;
    logic       beep512Hz, beep1kHz, alarm_active;
    logic [1:0] snooze_used;

    always #5 clk = ~clk;

    beep_scheduler #(
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .sec1         (sec1),
        .sec2         (sec2),
        .min1         (min1),
        .min2         (min2),
        .hour1        (hour1),
        .hour2        (hour2),
        .asec1        (asec1),
        .asec2        (asec2),
        .amin1        (amin1),
        .amin2        (amin2),
        .ahour1       (ahour1),
        .ahour2       (ahour2),
        .alarm_on     (alarm_on),
        .snooze_btn   (snooze_btn),
        .stop_btn     (stop_btn),
        .beep512Hz    (beep512Hz),
        .beep1kHz     (beep1kHz),
        .alarm_active (alarm_active),
        .snooze_used  (snooze_used)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: mode 0 = quiet, 1 = ringing, 2 = snoozing.
    int now, alarm_t;
    bit arm;
    int m_mode, m_left, m_used;
    bit m_b512, m_b1k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [23:0] to_bcd(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_step(input bit r, input bit tk, input bit sn, input bit sp);
        int mm, ss;
        bit pip, top;
        mm  = (now / 60) % 60;
        ss  = now % 60;
        pip = (mm == 59) && (ss == 50 || ss == 52 || ss == 54 || ss == 58);
        top = (mm == 0) && (ss == 0);
        if (r) begin
            m_mode = 0; m_left = 0; m_used = 0; m_b512 = 0; m_b1k = 0;
        end else if (m_mode != 0 && (!arm || sp)) begin
            m_mode = 0; m_used = 0; m_b512 = 0; m_b1k = 0;
        end else if (m_mode == 1 && sn && m_used < MAX_SNOOZE) begin
            m_mode = 2; m_left = SNOOZE_SEC; m_used++; m_b512 = 0; m_b1k = 0;
        end else if (tk) begin
            if (m_mode == 0) begin
                if (arm && now == alarm_t) begin
                    m_mode = 1; m_left = RING_SEC; m_used = 0; m_b512 = 0; m_b1k = 1;
                end else begin
                    m_b512 = pip; m_b1k = top;
                end
            end else begin
                m_left--;
                if (m_left == 0 && m_mode == 1) begin
                    m_mode = 0; m_used = 0; m_b512 = pip; m_b1k = top;
                end else if (m_left == 0) begin
                    m_mode = 1; m_left = RING_SEC; m_b512 = 0; m_b1k = 1;
                end else if (m_mode == 2) begin
                    m_b512 = pip; m_b1k = top;
                end
            end
        end
    endtask

    // One clock: drive at negedge, compare everything 1 ns after the posedge.
    // Time digits are garbage on non-tick cycles to show they are ignored.
    task automatic step(input bit tk, input bit sn = 1'b0, input bit sp = 1'b0, input bit r = 1'b0);
        @(negedge clk);
        rst        = r;
        tick_1hz   = tk;
        snooze_btn = sn;
        stop_btn   = sp;
        alarm_on   = arm;
        {hour1, hour2, min1, min2, sec1, sec2}       = tk ? to_bcd(now) : 24'($urandom);
        {ahour1, ahour2, amin1, amin2, asec1, asec2} = to_bcd(alarm_t);
        @(posedge clk);
        #1;
        model_step(r, tk, sn, sp);
        check("beep512Hz",    32'(beep512Hz),    32'(m_b512));
        check("beep1kHz",     32'(beep1kHz),     32'(m_b1k));
        check("alarm_active", 32'(alarm_active), 32'(m_mode != 0));
        check("snooze_used",  32'(snooze_used),  32'(m_used));
        if (tk) now = (now + 1) % 86400;
    endtask

    initial begin
        int n512, n1k, rises, max_used;
        bit prev, after;
        rst = 1'b1; tick_1hz = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0; alarm_on = 1'b0;
        {hour1, hour2, min1, min2, sec1, sec2}       = '0;
        {ahour1, ahour2, amin1, amin2, asec1, asec2} = '0;
        arm = 0; now = 0; alarm_t = hms(23, 0, 0);
        m_mode = 0; m_left = 0; m_used = 0; m_b512 = 0; m_b1k = 0;

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("reset_active", 32'(alarm_active), 0);
        check("reset_tones",  32'({beep512Hz, beep1kHz}), 0);

        // Hourly chime 12:59:49 .. 13:00:01.
        now = hms(12, 59, 49); n512 = 0; n1k = 0;
        repeat (13) begin
            step(1);
            n512 += int'(beep512Hz);
            n1k  += int'(beep1kHz);
            step(0);
        end
        check("chime_512_secs", n512, 4);
        check("chime_1k_secs",  n1k,  1);

        // Ring timeout.
        arm = 1; alarm_t = hms(7, 30, 0); now = hms(7, 29, 58); n1k = 0;
        repeat (10) begin
            step(1);
            n1k += int'(beep1kHz);
            step(0);
        end
        check("ring_1k_ticks",   n1k, RING_SEC);
        check("ring_end_active", 32'(alarm_active), 0);
        check("ring_end_used",   32'(snooze_used),  0);

        // Snooze in every ring until the limit is reached.
        alarm_t = hms(8, 0, 0); now = hms(7, 59, 59); rises = 0; max_used = 0; prev = 0;
        repeat (16) begin
            step(1);
            if (beep1kHz && !prev) rises++;
            prev = beep1kHz;
            if (int'(snooze_used) > max_used) max_used = int'(snooze_used);
            step(0, m_mode == 1);
            prev = beep1kHz;
            if (int'(snooze_used) > max_used) max_used = int'(snooze_used);
        end
        check("snooze_max_used",   max_used, MAX_SNOOZE);
        check("snooze_ring_count", rises, 3);
        check("snooze_end_active", 32'(alarm_active), 0);

        // Stop and snooze together while ringing.
        alarm_t = hms(9, 0, 0); now = hms(8, 59, 59);
        step(1); step(1);
        step(0, 1);
        repeat (SNOOZE_SEC) step(1);
        step(0, 1, 1);
        check("collide_active", 32'(alarm_active), 0);
        check("collide_used",   32'(snooze_used),  0);
        check("collide_1k",     32'(beep1kHz),     0);

        // Disarm while snoozing.
        alarm_t = hms(10, 0, 0); now = alarm_t;
        step(1); step(0, 1); step(1);
        arm = 0;
        step(0);
        check("disarm_active", 32'(alarm_active), 0);
        arm = 1;

        // Reset with a tick while ringing.
        alarm_t = hms(11, 0, 0); now = alarm_t;
        step(1); step(1);
        step(1, 0, 0, 1);
        check("rst_ring_outputs", 32'({beep512Hz, beep1kHz, alarm_active, snooze_used}), 0);

        // Alarm on the hour, then the same hour with the alarm disarmed.
        for (int pass = 0; pass < 2; pass++) begin
            arm = (pass == 0); alarm_t = hms(14, 0, 0); now = hms(13, 59, 45);
            n512 = 0; n1k = 0;
            repeat (24) begin
                after = (now >= alarm_t);
                step(1);
                if (after) begin
                    n512 += int'(beep512Hz);
                    n1k  += int'(beep1kHz);
                end
                step(0);
            end
            check(pass == 0 ? "top_alarm_1k" : "top_chime_1k", n1k, pass == 0 ? RING_SEC : 1);
            check("top_512_after", n512, 0);
        end
        arm = 1;

        // Random traffic around the chime window with alarms set just ahead.
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) begin
                now     = hms(int'($urandom_range(23, 0)), 59, int'($urandom_range(59, 30)));
                alarm_t = (now + int'($urandom_range(40, 0))) % 86400;
                arm     = 1;
            end
            if ($urandom_range(199, 0) == 0) arm = !arm;
            step($urandom_range(2, 0) == 0, $urandom_range(7, 0) == 0,
                 $urandom_range(39, 0) == 0, $urandom_range(499, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
